uart_rx_ex: RTL and testbench

Parametrised UART receiver, the next-generation serial input stage for the ONC-16 host link. It supports a configurable baud rate, 5–9 data bits, optional even/odd parity and 1 or 2 stop bits. Each bit is decided by a 3-sample majority vote, and the block detects false starts, framing errors, parity errors and overrun. Received words are delivered through a valid/ready holding register to the downstream command decoder or FIFO.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_bit_sampler.sv | 71 +++++++
 rtl/uart_rx_ex.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_ex.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the ONC-16 host-link UART blocks.
// Provides the parity mode codes, the receiver state encoding and the
// bit-period rounding helper used by both the receiver and transmitter.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Clock cycles per bit, rounded to nearest.
  function automatic int bit_cycles(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Line front end for the UART receiver.
// Synchronises rx, runs the per-bit timer and takes three samples around
// the bit centre (H-1, H, H+1 with H = BIT_CYCLES/2).
// Ports:
//   clock_50M  in   system clock
//   n_rst      in   async active-low reset
//   rx         in   raw serial line
//   run        in   timer enable; while low the timer is held at 0
//   rxs        out  synchronised line
//   bit_val    out  2-of-3 majority, valid in the bit_done cycle
//   bit_done   out  one-cycle strobe at the H+1 sample of each bit
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int BIT_CYCLES = 434
) (
  input  logic clock_50M,
  input  logic n_rst,
  input  logic rx,
  input  logic run,
  output logic rxs,
  output logic bit_val,
  output logic bit_done
);

  localparam int TW = $clog2(BIT_CYCLES);
  localparam int H  = BIT_CYCLES / 2;
  localparam logic [TW-1:0] T_LAST = TW'(BIT_CYCLES - 1);
  localparam logic [TW-1:0] T_S0   = TW'(H - 1);
  localparam logic [TW-1:0] T_S1   = TW'(H);
  localparam logic [TW-1:0] T_S2   = TW'(H + 1);

  logic          rx_meta;
  logic [TW-1:0] timer;
  logic          s0, s1;

  always_ff @(posedge clock_50M or negedge n_rst) begin
    if (!n_rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clock_50M or negedge n_rst) begin
    if (!n_rst) begin
      timer <= '0;
    end else if (!run || timer == T_LAST) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clock_50M or negedge n_rst) begin
    if (!n_rst) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
    end else if (run) begin
      if (timer == T_S0) s0 <= rxs;
      if (timer == T_S1) s1 <= rxs;
    end
  end

  // Third sample is the live rxs so the decision lands in the H+1 cycle.
  assign bit_val  = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
  assign bit_done = run && (timer == T_S2);

endmodule

// File: rtl/uart_rx_ex.sv
// UART receiver, 5..9 data bits, optional parity, 1 or 2 stop bits.
// Words are delivered through a valid/ready holding register.
// Ports:
//   clock_50M   in   system clock
//   n_rst       in   async active-low reset
//   rx          in   serial line, idle high
//   rx_ready    in   downstream accepts current word
//   rx_valid    out  holding register holds an unconsumed word
//   rx_data     out  received word (LSB first on the line)
//   frame_err   out  a stop bit sampled low (qualified by rx_valid)
//   parity_err  out  parity mismatch (qualified by rx_valid)
//   overrun     out  sticky, a complete word was dropped
//
// state   | meaning
// IDLE    | waiting for a falling edge; armed once the line is seen high
// START   | checking the start bit, majority 1 is a false start
// DATA    | shifting in DATA_BITS bits, LSB first
// PARITY  | checking the parity bit
// STOP    | checking stop bits; word completes at the last decision
module uart_rx_ex
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock_50M,
  input  logic                 n_rst,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int BIT_CYCLES = bit_cycles(CLK_HZ, BAUD);

  generate
    if (BIT_CYCLES < 8) begin : g_bad_baud
      $error("uart_rx_ex: BIT_CYCLES must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
      $error("uart_rx_ex: DATA_BITS must be 5..9");
    end
  endgenerate

  logic [2:0]           state;
  logic                 armed;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 pend_perr;
  logic                 pend_ferr;

  logic rxs, bit_val, bit_done, run;
  logic last_stop, done_ferr, par_x, par_bad;
  logic consume, load, drop;

  assign run = (state != ST_IDLE);

  uart_bit_sampler #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_sampler (
    .clock_50M(clock_50M),
    .n_rst    (n_rst),
    .rx       (rx),
    .run      (run),
    .rxs      (rxs),
    .bit_val  (bit_val),
    .bit_done (bit_done)
  );

  assign last_stop = (state == ST_STOP) && bit_done && (STOP_BITS == 1 || stop_cnt);
  assign done_ferr = pend_ferr | ~bit_val;
  assign par_x     = (^shreg) ^ bit_val;
  assign par_bad   = (PARITY == PAR_ODD) ? ~par_x : par_x;

  assign consume = rx_valid & rx_ready;
  assign load    = last_stop & (~rx_valid | consume);
  assign drop    = last_stop & ~load;

  always_ff @(posedge clock_50M or negedge n_rst) begin
    if (!n_rst) begin
      state     <= ST_IDLE;
      armed     <= 1'b1;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      shreg     <= '0;
      pend_perr <= 1'b0;
      pend_ferr <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rxs) begin
            armed <= 1'b1;
          end else if (armed) begin
            state     <= ST_START;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            pend_perr <= 1'b0;
            pend_ferr <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_done) begin
            if (bit_val) begin
              state <= ST_IDLE;
              armed <= 1'b0;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 4'(DATA_BITS - 1)) begin
              state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (bit_done) begin
            pend_perr <= par_bad;
            state     <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            if (!bit_val) pend_ferr <= 1'b1;
            // Leave at the decision, disarmed, so a held break yields one word.
            if (last_stop) begin
              state <= ST_IDLE;
              armed <= 1'b0;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_50M or negedge n_rst) begin
    if (!n_rst) begin
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        rx_data    <= shreg;
        frame_err  <= done_ferr;
        parity_err <= pend_perr;
      end
      rx_valid <= load | (rx_valid & ~consume);
      overrun  <= drop | (overrun & ~consume);
    end
  end

endmodule

// File: tb/tb_uart_rx_ex.sv
// Directed bench for uart_rx_ex: four instances cover the default
// configuration, even parity, odd parity and 9-bit / 2-stop framing.
module tb_uart_rx_ex;

  localparam int BC_DEF  = 434;
  localparam int BC_FAST = 10;

  logic       clk;
  logic       n_rst;
  logic       rx_l [4];
  logic       rdy  [4];
  logic       v    [4];
  logic       fe   [4];
  logic       pe   [4];
  logic       ov   [4];
  logic [7:0] d_def, d_even, d_odd;
  logic [8:0] d_nine;
  logic [8:0] dat  [4];

  int total = 0;
  int bad   = 0;

  int         wcnt   [4] = '{default: 0};
  int         runlen [4] = '{default: 0};
  int         maxrun [4] = '{default: 0};
  logic       pv     [4] = '{default: 1'b0};
  logic       pc     [4] = '{default: 1'b0};
  logic [8:0] last_d [4] = '{default: 9'h0};
  logic       last_f [4] = '{default: 1'b0};
  logic       last_p [4] = '{default: 1'b0};

  assign dat[0] = {1'b0, d_def};
  assign dat[1] = {1'b0, d_even};
  assign dat[2] = {1'b0, d_odd};
  assign dat[3] = d_nine;

  uart_rx_ex u_def (
    .clock_50M(clk), .n_rst(n_rst), .rx(rx_l[0]), .rx_ready(rdy[0]),
    .rx_valid(v[0]), .rx_data(d_def), .frame_err(fe[0]),
    .parity_err(pe[0]), .overrun(ov[0])
  );

  uart_rx_ex #(.BAUD(5_000_000), .PARITY(1)) u_even (
    .clock_50M(clk), .n_rst(n_rst), .rx(rx_l[1]), .rx_ready(rdy[1]),
    .rx_valid(v[1]), .rx_data(d_even), .frame_err(fe[1]),
    .parity_err(pe[1]), .overrun(ov[1])
  );

  uart_rx_ex #(.BAUD(5_000_000), .PARITY(2)) u_odd (
    .clock_50M(clk), .n_rst(n_rst), .rx(rx_l[2]), .rx_ready(rdy[2]),
    .rx_valid(v[2]), .rx_data(d_odd), .frame_err(fe[2]),
    .parity_err(pe[2]), .overrun(ov[2])
  );

  uart_rx_ex #(.BAUD(5_000_000), .DATA_BITS(9), .STOP_BITS(2)) u_nine (
    .clock_50M(clk), .n_rst(n_rst), .rx(rx_l[3]), .rx_ready(rdy[3]),
    .rx_valid(v[3]), .rx_data(d_nine), .frame_err(fe[3]),
    .parity_err(pe[3]), .overrun(ov[3])
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Word monitor: a new word is a valid cycle not preceded by a held word.
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (v[c]) begin
        if (!pv[c] || pc[c]) begin
          wcnt[c]   <= wcnt[c] + 1;
          last_d[c] <= dat[c];
          last_f[c] <= fe[c];
          last_p[c] <= pe[c];
        end
        runlen[c] <= runlen[c] + 1;
        if (runlen[c] + 1 > maxrun[c]) maxrun[c] <= runlen[c] + 1;
      end else begin
        runlen[c] <= 0;
      end
      pv[c] <= v[c];
      pc[c] <= v[c] & rdy[c];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input int ch, input logic b, input int n);
    rx_l[ch] = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int ch, input int bc, input int nbits,
                            input logic [8:0] data, input bit par_en,
                            input logic par_bit, input int nstop,
                            input logic last_stop);
    drive_bit(ch, 1'b0, bc);
    for (int i = 0; i < nbits; i++) drive_bit(ch, data[i], bc);
    if (par_en) drive_bit(ch, par_bit, bc);
    for (int s = 0; s < nstop; s++) drive_bit(ch, (s == nstop - 1) ? last_stop : 1'b1, bc);
    drive_bit(ch, 1'b1, 2 * bc);
  endtask

  task automatic chk_word(input int ch, input string tag, input int exp_cnt,
                          input logic [8:0] exp_d, input logic exp_f, input logic exp_p);
    check({tag, "_cnt"},  wcnt[ch],   exp_cnt);
    check({tag, "_data"}, last_d[ch], {23'h0, exp_d});
    check({tag, "_ferr"}, last_f[ch], {31'h0, exp_f});
    check({tag, "_perr"}, last_p[ch], {31'h0, exp_p});
  endtask

  initial begin
    n_rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      rx_l[c] = 1'b1;
      rdy[c]  = 1'b1;
    end
    repeat (5) @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    check("rst_valid",   v[0],  0);
    check("rst_data",    d_def, 0);
    check("rst_ferr",    fe[0], 0);
    check("rst_perr",    pe[0], 0);
    check("rst_overrun", ov[0], 0);
    check("rst_valid9",  v[3],  0);

    // Default config, two back-to-back-ish words.
    send_frame(0, BC_DEF, 8, 9'h055, 1'b0, 1'b0, 1, 1'b1);
    chk_word(0, "w55", 1, 9'h055, 1'b0, 1'b0);
    send_frame(0, BC_DEF, 8, 9'h0AA, 1'b0, 1'b0, 1, 1'b1);
    chk_word(0, "wAA", 2, 9'h0AA, 1'b0, 1'b0);
    check("valid_one_cycle", maxrun[0], 1);

    // 40% bit glitch, then a real frame.
    drive_bit(0, 1'b0, 174);
    drive_bit(0, 1'b1, BC_DEF);
    check("glitch_cnt",   wcnt[0], 2);
    check("glitch_valid", v[0],    0);
    send_frame(0, BC_DEF, 8, 9'h03C, 1'b0, 1'b0, 1, 1'b1);
    chk_word(0, "w3C", 3, 9'h03C, 1'b0, 1'b0);

    // Break for two frame times yields exactly one word.
    drive_bit(0, 1'b0, 20 * BC_DEF);
    drive_bit(0, 1'b1, 2 * BC_DEF);
    chk_word(0, "brk", 4, 9'h000, 1'b1, 1'b0);
    send_frame(0, BC_DEF, 8, 9'h081, 1'b0, 1'b0, 1, 1'b1);
    chk_word(0, "w81", 5, 9'h081, 1'b0, 1'b0);

    // Overrun: second word dropped while the first is held.
    rdy[0] = 1'b0;
    send_frame(0, BC_DEF, 8, 9'h011, 1'b0, 1'b0, 1, 1'b1);
    send_frame(0, BC_DEF, 8, 9'h022, 1'b0, 1'b0, 1, 1'b1);
    check("ovr_cnt",   wcnt[0], 6);
    check("ovr_data",  d_def,   8'h11);
    check("ovr_valid", v[0],    1);
    check("ovr_flag",  ov[0],   1);
    rdy[0] = 1'b1;
    @(negedge clk);
    rdy[0] = 1'b0;
    check("ovr_consumed_valid", v[0],  0);
    check("ovr_consumed_flag",  ov[0], 0);

    // Even parity: 0x07 has three ones, parity bit 1 is correct.
    send_frame(1, BC_FAST, 8, 9'h007, 1'b1, 1'b1, 1, 1'b1);
    chk_word(1, "even_ok", 1, 9'h007, 1'b0, 1'b0);
    send_frame(1, BC_FAST, 8, 9'h007, 1'b1, 1'b0, 1, 1'b1);
    chk_word(1, "even_bad", 2, 9'h007, 1'b0, 1'b1);

    // Odd parity: opposite expectations.
    send_frame(2, BC_FAST, 8, 9'h007, 1'b1, 1'b1, 1, 1'b1);
    chk_word(2, "odd_bad", 1, 9'h007, 1'b0, 1'b1);
    send_frame(2, BC_FAST, 8, 9'h007, 1'b1, 1'b0, 1, 1'b1);
    chk_word(2, "odd_ok", 2, 9'h007, 1'b0, 1'b0);

    // 9 data bits, 2 stop bits.
    send_frame(3, BC_FAST, 9, 9'h1A5, 1'b0, 1'b0, 2, 1'b1);
    chk_word(3, "nine_ok", 1, 9'h1A5, 1'b0, 1'b0);
    send_frame(3, BC_FAST, 9, 9'h1A5, 1'b0, 1'b0, 2, 1'b0);
    chk_word(3, "nine_stop2", 2, 9'h1A5, 1'b1, 1'b0);

    // Reset in the middle of the data bits aborts the frame.
    drive_bit(3, 1'b0, BC_FAST);
    drive_bit(3, 1'b1, BC_FAST);
    drive_bit(3, 1'b0, BC_FAST);
    drive_bit(3, 1'b1, BC_FAST);
    drive_bit(3, 1'b0, BC_FAST);
    n_rst   = 1'b0;
    rx_l[3] = 1'b1;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (20 * BC_FAST) @(negedge clk);
    check("midrst_cnt",   wcnt[3], 2);
    check("midrst_valid", v[3],    0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
